uart_parity_unit: RTL and testbench
===================================

Name: uart_parity_unit

Overview:
Parametrised serial parity generator/checker shared by TxCore and RxCore. Accumulates parity one bit at a time on bit strobes, so the result is correct for both Tx and Rx bit-counter behaviour. Supports runtime data length 5..DATA_W and five parity modes. In Rx use, it compares the received parity bit against the expected value and flags mismatches.

Parameters:
DATA_W, 8, maximum data bits per frame; legal range 5..9.
CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
p_FrameStart_i  input  1  one-cycle pulse; starts a new frame and samples configuration
DataBits_i  input  CNT_W  data bits per frame; sampled on p_FrameStart_i
Mode_i  input  3  parity mode: 000 none, 001 even, 010 odd, 011 mark, 100 space; 101..111 treated as none; sampled on p_FrameStart_i
p_BitStrobe_i  input  1  one-cycle pulse; the data bit on BitValue_i is valid
BitValue_i  input  1  serial data bit, LSB first
p_ParityStrobe_i  input  1  one-cycle pulse; the received parity bit on RxParity_i is valid (Rx only)
RxParity_i  input  1  received parity bit
ParityBit_o  output  1  expected/transmit parity bit, registered
ParityValid_o  output  1  high while ParityBit_o is final (PARWAIT state)
p_ParityErr_o  output  1  one-cycle pulse on parity mismatch
p_FrameDone_o  output  1  one-cycle pulse when the frame's parity phase completes
Busy_o  output  1  high in ACCUM or PARWAIT
BitCnt_o  output  CNT_W  data bits accumulated so far

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, acc=0, count=0, ParityBit_o=1, ParityValid_o=0, p_ParityErr_o=0, p_FrameDone_o=0, Busy_o=0, BitCnt_o=0. Reset overrides every other input, including mid-frame.
- States: IDLE, ACCUM, PARWAIT.
- p_FrameStart_i has priority in any state:
  - acc<=0, count<=0, state<=ACCUM.
  - Latches Mode_i and clamped DataBits_i: values <5 become 5; values >DATA_W become DATA_W.
  - A p_BitStrobe_i in the same cycle is discarded.
- IDLE: bit and parity strobes are ignored.
- ACCUM, on p_BitStrobe_i: acc<=acc^BitValue_i and count<=count+1.
  - If count+1 equals the latched length and mode is none: go to IDLE, pulse p_FrameDone_o next cycle.
  - If count+1 equals the latched length and mode is not none: go to PARWAIT.
- Parity value, registered into ParityBit_o on entering PARWAIT:
  - even: final acc; odd: ~final acc; mark: 1; space: 0.
  - ParityValid_o is high the cycle after the last data strobe (latency 1).
- PARWAIT:
  - ParityBit_o and ParityValid_o hold until exit.
  - Extra p_BitStrobe_i is ignored and count saturates.
  - On p_ParityStrobe_i: p_ParityErr_o<=(RxParity_i!=ParityBit_o), p_FrameDone_o<=1, state<=IDLE.
  - Tx usage: the Tx FSM issues p_ParityStrobe_i with RxParity_i tied to ParityBit_o, so no error is raised.
- Leaving PARWAIT: ParityValid_o<=0 and ParityBit_o<=1 (idle line level).
- Configuration changes mid-frame have no effect until the next p_FrameStart_i.
- Simultaneous p_BitStrobe_i and p_ParityStrobe_i in ACCUM: the parity strobe is ignored.

Optional Feature:
Macro UART_PARITY_ERR_CNT_EN.
- Defined: adds output ErrCnt_o (8 bits) and input p_ErrCntClr_i (1 bit).
  - Saturating count of p_ParityErr_o pulses; stops at 255.
  - Reset to 0 by rst; clear has priority over increment in the same cycle.
- Undefined: neither port exists; no counter logic is synthesised.

Decomposition:
- Shared package uart_pkg:
  - Parity-mode encodings PAR_NONE/EVEN/ODD/MARK/SPACE.
  - State encodings IDLE/ACCUM/PARWAIT (one-hot, consistent with the other UART FSMs).
  - Constant MIN_DATA_BITS=5.
- One natural sub-module, uart_parity_errcnt: the saturating error counter, instantiated only under UART_PARITY_ERR_CNT_EN.

Test Plan:
- Even parity, 8 bits, data 0xA5 strobed LSB first -> ParityBit_o=0, ParityValid_o high 1 cycle after 8th strobe, BitCnt_o=8.
- Odd parity, DataBits_i=7, data 0x13 -> ParityBit_o=0; RxParity_i=1 on parity strobe -> p_ParityErr_o pulses once, p_FrameDone_o pulses.
- Mark and space modes, data 0xFF, 8 bits -> ParityBit_o=1 and 0 respectively; mode none -> p_FrameDone_o 1 cycle after 8th strobe, ParityValid_o never asserts.
- DataBits_i=3 -> clamped to 5: PARWAIT entered after exactly 5 strobes; DataBits_i=12 with DATA_W=8 -> entered after 8.
- p_FrameStart_i after 4 bits -> count=0, acc=0, Busy_o stays 1; new 0x01 even frame -> ParityBit_o=1; rst asserted mid-PARWAIT -> all outputs at reset values next cycle.
- With UART_PARITY_ERR_CNT_EN: 260 bad-parity frames -> ErrCnt_o=255; p_ErrCntClr_i coincident with an error -> ErrCnt_o=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode and FSM state encodings, data-length limits,
// and helpers to decode the parity mode and compute the parity bit.
package uart_pkg;

   localparam int unsigned MIN_DATA_BITS = 5;
   localparam int unsigned MODE_W        = 3;
   localparam int unsigned ERR_CNT_W     = 8;

   typedef enum logic [MODE_W-1:0] {
      PAR_NONE  = 3'b000,
      PAR_EVEN  = 3'b001,
      PAR_ODD   = 3'b010,
      PAR_MARK  = 3'b011,
      PAR_SPACE = 3'b100
   } par_mode_e;

   // One-hot, matching the other UART FSMs
   typedef enum logic [2:0] {
      IDLE    = 3'b001,
      ACCUM   = 3'b010,
      PARWAIT = 3'b100
   } par_state_e;

   // Reserved encodings 101..111 behave as "no parity"
   function automatic par_mode_e decode_mode(input logic [MODE_W-1:0] m);
      par_mode_e res;
      case (m)
         3'b001:  res = PAR_EVEN;
         3'b010:  res = PAR_ODD;
         3'b011:  res = PAR_MARK;
         3'b100:  res = PAR_SPACE;
         default: res = PAR_NONE;
      endcase
      return res;
   endfunction

   // Parity bit from the XOR of all data bits
   function automatic logic parity_value(input par_mode_e mode, input logic acc);
      logic res;
      case (mode)
         PAR_EVEN:  res = acc;
         PAR_ODD:   res = ~acc;
         PAR_MARK:  res = 1'b1;
         PAR_SPACE: res = 1'b0;
         default:   res = 1'b1;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/uart_parity_errcnt.sv
// Saturating parity-error counter.
// Ports: clk, rst (sync, active-high), clr (clear, wins over inc),
//        inc (one-cycle error pulse), cnt (count, sticks at all-ones).
module uart_parity_errcnt
   import uart_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 inc,
   output logic [ERR_CNT_W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {ERR_CNT_W{1'b1}})) begin
         cnt <= cnt + ERR_CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_parity_unit.sv
// Serial parity generator/checker shared by the Tx and Rx cores. Parity is
// accumulated one bit per strobe; in Rx use the received parity bit is compared
// against the expected value.
// Ports: clk, rst (sync, active-high); p_FrameStart_i / DataBits_i / Mode_i start a
//        frame and latch its config; p_BitStrobe_i / BitValue_i feed data bits;
//        p_ParityStrobe_i / RxParity_i deliver the parity bit; outputs ParityBit_o,
//        ParityValid_o, p_ParityErr_o, p_FrameDone_o, Busy_o, BitCnt_o.
// Optional: define UART_PARITY_ERR_CNT_EN to add p_ErrCntClr_i and ErrCnt_o, a
//        saturating count of parity errors.
module uart_parity_unit
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CNT_W  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 p_FrameStart_i,
   input  logic [CNT_W-1:0]     DataBits_i,
   input  logic [MODE_W-1:0]    Mode_i,
   input  logic                 p_BitStrobe_i,
   input  logic                 BitValue_i,
   input  logic                 p_ParityStrobe_i,
   input  logic                 RxParity_i,
`ifdef UART_PARITY_ERR_CNT_EN
   input  logic                 p_ErrCntClr_i,
   output logic [ERR_CNT_W-1:0] ErrCnt_o,
`endif
   output logic                 ParityBit_o,
   output logic                 ParityValid_o,
   output logic                 p_ParityErr_o,
   output logic                 p_FrameDone_o,
   output logic                 Busy_o,
   output logic [CNT_W-1:0]     BitCnt_o
);

   par_state_e       state, state_nxt;
   par_mode_e        mode, mode_nxt;
   logic [CNT_W-1:0] len, len_nxt;
   logic [CNT_W-1:0] count, count_nxt;
   logic             acc, acc_nxt;
   logic             par_bit_nxt, par_valid_nxt, par_err_nxt, done_nxt, busy_nxt;
   logic [CNT_W-1:0] len_clamped_c;

   // Frame length clamped into MIN_DATA_BITS..DATA_W
   always_comb begin
      len_clamped_c = DataBits_i;
      if (DataBits_i < CNT_W'(MIN_DATA_BITS)) begin
         len_clamped_c = CNT_W'(MIN_DATA_BITS);
      end else if (DataBits_i > CNT_W'(DATA_W)) begin
         len_clamped_c = CNT_W'(DATA_W);
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         mode          <= PAR_NONE;
         len           <= CNT_W'(DATA_W);
         count         <= '0;
         acc           <= 1'b0;
         ParityBit_o   <= 1'b1;
         ParityValid_o <= 1'b0;
         p_ParityErr_o <= 1'b0;
         p_FrameDone_o <= 1'b0;
         Busy_o        <= 1'b0;
      end else begin
         state         <= state_nxt;
         mode          <= mode_nxt;
         len           <= len_nxt;
         count         <= count_nxt;
         acc           <= acc_nxt;
         ParityBit_o   <= par_bit_nxt;
         ParityValid_o <= par_valid_nxt;
         p_ParityErr_o <= par_err_nxt;
         p_FrameDone_o <= done_nxt;
         Busy_o        <= busy_nxt;
      end
   end

   // Next-state and output logic; frame start overrides everything else
   always_comb begin
      state_nxt     = state;
      mode_nxt      = mode;
      len_nxt       = len;
      count_nxt     = count;
      acc_nxt       = acc;
      par_bit_nxt   = ParityBit_o;
      par_valid_nxt = ParityValid_o;
      par_err_nxt   = 1'b0;
      done_nxt      = 1'b0;

      if (p_FrameStart_i) begin
         state_nxt     = ACCUM;
         mode_nxt      = decode_mode(Mode_i);
         len_nxt       = len_clamped_c;
         count_nxt     = '0;
         acc_nxt       = 1'b0;
         par_bit_nxt   = 1'b1;
         par_valid_nxt = 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               // A parity strobe coinciding with a bit strobe is ignored here
               if (p_BitStrobe_i) begin
                  acc_nxt   = acc ^ BitValue_i;
                  count_nxt = count + CNT_W'(1);
                  if (count_nxt == len) begin
                     if (mode == PAR_NONE) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                     end else begin
                        state_nxt     = PARWAIT;
                        par_bit_nxt   = parity_value(mode, acc_nxt);
                        par_valid_nxt = 1'b1;
                     end
                  end
               end
            end
            PARWAIT: begin
               // Tx ties RxParity_i to ParityBit_o, so only Rx can flag an error
               if (p_ParityStrobe_i) begin
                  state_nxt     = IDLE;
                  par_err_nxt   = (RxParity_i != ParityBit_o);
                  done_nxt      = 1'b1;
                  par_bit_nxt   = 1'b1;
                  par_valid_nxt = 1'b0;
               end
            end
            default: ;
         endcase
      end

      busy_nxt = (state_nxt != IDLE);
   end

   assign BitCnt_o = count;

`ifdef UART_PARITY_ERR_CNT_EN
   uart_parity_errcnt u_errcnt (
      .clk (clk),
      .rst (rst),
      .clr (p_ErrCntClr_i),
      .inc (p_ParityErr_o),
      .cnt (ErrCnt_o)
   );
`endif

endmodule

// File: tb/tb_uart_parity_unit.sv
// Self-checking bench for uart_parity_unit: directed frames from the test plan
// followed by randomized frames, checked against a frame-level parity model.
module tb_uart_parity_unit;
   import uart_pkg::*;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             p_FrameStart_i;
   logic [CNT_W-1:0] DataBits_i;
   logic [2:0]       Mode_i;
   logic             p_BitStrobe_i;
   logic             BitValue_i;
   logic             p_ParityStrobe_i;
   logic             RxParity_i;
   logic             ParityBit_o;
   logic             ParityValid_o;
   logic             p_ParityErr_o;
   logic             p_FrameDone_o;
   logic             Busy_o;
   logic [CNT_W-1:0] BitCnt_o;
`ifdef UART_PARITY_ERR_CNT_EN
   logic             p_ErrCntClr_i;
   logic [7:0]       ErrCnt_o;
   int               exp_errcnt = 0;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_parity_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .p_FrameStart_i   (p_FrameStart_i),
      .DataBits_i       (DataBits_i),
      .Mode_i           (Mode_i),
      .p_BitStrobe_i    (p_BitStrobe_i),
      .BitValue_i       (BitValue_i),
      .p_ParityStrobe_i (p_ParityStrobe_i),
      .RxParity_i       (RxParity_i),
`ifdef UART_PARITY_ERR_CNT_EN
      .p_ErrCntClr_i    (p_ErrCntClr_i),
      .ErrCnt_o         (ErrCnt_o),
`endif
      .ParityBit_o      (ParityBit_o),
      .ParityValid_o    (ParityValid_o),
      .p_ParityErr_o    (p_ParityErr_o),
      .p_FrameDone_o    (p_FrameDone_o),
      .Busy_o           (Busy_o),
      .BitCnt_o         (BitCnt_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: frame-level rules in plain arithmetic
   function automatic int model_len(input int bits);
      if (bits < 5) return 5;
      if (bits > int'(DATA_W)) return int'(DATA_W);
      return bits;
   endfunction

   function automatic bit model_none(input int m);
      return !(m >= 1 && m <= 4);
   endfunction

   function automatic logic model_parity(input int data, input int len, input int m);
      int ones;
      ones = $countones(data & ((1 << len) - 1));
      case (m)
         1:       return logic'(ones % 2 == 1);
         2:       return logic'(ones % 2 == 0);
         3:       return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Advance one clock; outputs are sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      p_FrameStart_i   = 1'b0;
      p_BitStrobe_i    = 1'b0;
      BitValue_i       = 1'b0;
      p_ParityStrobe_i = 1'b0;
      RxParity_i       = 1'b0;
`ifdef UART_PARITY_ERR_CNT_EN
      p_ErrCntClr_i    = 1'b0;
`endif
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_pbit"},  ParityBit_o,   1);
      check({tag, "_valid"}, ParityValid_o, 0);
      check({tag, "_err"},   p_ParityErr_o, 0);
      check({tag, "_done"},  p_FrameDone_o, 0);
      check({tag, "_busy"},  Busy_o,        0);
      check({tag, "_cnt"},   BitCnt_o,      0);
   endtask

   // Frame start; a coincident bit strobe must be discarded
   task automatic start_frame(input int bits, input int m);
      p_FrameStart_i = 1'b1;
      DataBits_i     = CNT_W'(bits);
      Mode_i         = 3'(m);
      p_BitStrobe_i  = 1'($urandom % 2);
      BitValue_i     = 1'b1;
      step();
      idle_inputs();
      check("start_busy",  Busy_o,        1);
      check("start_cnt",   BitCnt_o,      0);
      check("start_valid", ParityValid_o, 0);
      // Config changes after the start must have no effect
      DataBits_i = CNT_W'($urandom);
      Mode_i     = 3'($urandom);
   endtask

   task automatic send_bit(input logic v, input bit noise);
      p_BitStrobe_i    = 1'b1;
      BitValue_i       = v;
      p_ParityStrobe_i = noise ? 1'($urandom % 2) : 1'b0;
      RxParity_i       = 1'($urandom % 2);
      step();
      idle_inputs();
   endtask

   task automatic run_frame(input int data, input int bits, input int m,
                            input bit bad, input bit noise, input bit clr_on_err);
      int   len;
      bit   none;
      logic expp;
      len  = model_len(bits);
      none = model_none(m);
      expp = model_parity(data, len, m);
      start_frame(bits, m);
      for (int i = 0; i < len; i++) begin
         if (noise) repeat ($urandom_range(0, 2)) step();
         send_bit(1'((data >> i) & 1), noise);
         check("bitcnt", BitCnt_o, 32'(i + 1));
         if (i < len - 1) begin
            check("acc_busy",  Busy_o,        1);
            check("acc_valid", ParityValid_o, 0);
         end
      end
      if (none) begin
         check("none_done",  p_FrameDone_o, 1);
         check("none_valid", ParityValid_o, 0);
         check("none_busy",  Busy_o,        0);
         check("none_pbit",  ParityBit_o,   1);
         step();
         check("none_done_clr", p_FrameDone_o, 0);
         check("none_valid2",   ParityValid_o, 0);
         return;
      end
      check("pw_valid", ParityValid_o, 1);
      check("pw_pbit",  ParityBit_o,   32'(expp));
      check("pw_busy",  Busy_o,        1);
      check("pw_done",  p_FrameDone_o, 0);
      repeat ($urandom_range(0, 2)) begin
         send_bit(1'($urandom % 2), 1'b0);
         check("pw_sat_cnt", BitCnt_o,      32'(len));
         check("pw_hold",    ParityBit_o,   32'(expp));
         check("pw_hold_v",  ParityValid_o, 1);
      end
      p_ParityStrobe_i = 1'b1;
      RxParity_i       = bad ? ~expp : expp;
      step();
      idle_inputs();
      check("par_err",   p_ParityErr_o, 32'(bad));
      check("par_done",  p_FrameDone_o, 1);
      check("par_valid", ParityValid_o, 0);
      check("par_pbit",  ParityBit_o,   1);
      check("par_busy",  Busy_o,        0);
`ifdef UART_PARITY_ERR_CNT_EN
      p_ErrCntClr_i = clr_on_err;
      step();
      idle_inputs();
      if (clr_on_err) exp_errcnt = 0;
      else if (bad && exp_errcnt < 255) exp_errcnt++;
      check("errcnt", ErrCnt_o, 32'(exp_errcnt));
`else
      step();
`endif
      check("err_clr",  p_ParityErr_o, 0);
      check("done_clr", p_FrameDone_o, 0);
   endtask

   initial begin
      idle_inputs();
      DataBits_i = '0;
      Mode_i     = '0;
      rst        = 1'b1;
      step();
      step();
      check_reset_vals("rst");
`ifdef UART_PARITY_ERR_CNT_EN
      check("rst_errcnt", ErrCnt_o, 0);
`endif
      rst = 1'b0;
      step();
      // Strobes while idle are ignored
      send_bit(1'b1, 1'b1);
      check_reset_vals("idle_ign");

      run_frame(32'hA5, 8, 1, 1'b0, 1'b0, 1'b0);  // even -> 0
      run_frame(32'h13, 7, 2, 1'b1, 1'b0, 1'b0);  // odd -> 0, bad rx parity
      run_frame(32'hFF, 8, 3, 1'b0, 1'b0, 1'b0);  // mark
      run_frame(32'hFF, 8, 4, 1'b0, 1'b0, 1'b0);  // space
      run_frame(32'hFF, 8, 0, 1'b0, 1'b0, 1'b0);  // none
      run_frame(32'h3C, 8, 6, 1'b0, 1'b0, 1'b0);  // reserved mode = none
      run_frame(32'h1F, 3, 1, 1'b0, 1'b0, 1'b0);  // clamp up to 5
      run_frame(32'h1FF, 12, 2, 1'b0, 1'b0, 1'b0); // clamp down to 8

      // Restart after 4 bits: accumulator must clear
      start_frame(8, 1);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
      check("pre_restart_cnt", BitCnt_o, 4);
      run_frame(32'h01, 8, 1, 1'b0, 1'b0, 1'b0);   // even -> 1

      // Reset in the middle of PARWAIT
      start_frame(5, 1);
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
      check("pre_rst_valid", ParityValid_o, 1);
      rst = 1'b1;
      step();
      check_reset_vals("mid_rst");
      rst = 1'b0;
      step();
`ifdef UART_PARITY_ERR_CNT_EN
      exp_errcnt = 0;
`endif

      // Randomized frames
      for (int f = 0; f < 40; f++) begin
         run_frame(int'($urandom_range(0, 511)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 7)), 1'($urandom % 2), 1'b1, 1'b0);
      end

`ifdef UART_PARITY_ERR_CNT_EN
      for (int f = 0; f < 260; f++) run_frame(int'($urandom), 5, 1, 1'b1, 1'b0, 1'b0);
      check("errcnt_sat", ErrCnt_o, 255);
      run_frame(32'h5, 5, 2, 1'b1, 1'b0, 1'b1);
      check("errcnt_clr", ErrCnt_o, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
